// File: rtl/rob_core.sv
// rob_core: 16-entry in-order reorder buffer with rename, CDB capture, operand query and flush; ROB_CDB_BYPASS_EN forwards CDB onto queries.
module rob_core #(
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 issue_valid,
  input  logic                 issue_has_rd,
  input  logic [4:0]           issue_rd,
  output logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic                 rob_full,
  output logic                 rf_issue,
  output logic [4:0]           rf_issue_rd,
  output logic [ROB_POS_W-1:0] rf_issue_rob_pos,
  input  logic                 cdb_valid,
  input  logic [ROB_POS_W-1:0] cdb_rob_pos,
  input  logic [31:0]          cdb_val,
  output logic                 commit,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_val,
  input  logic [ROB_POS_W-1:0] qry1_pos,
  input  logic [ROB_POS_W-1:0] qry2_pos,
  output logic                 qry1_ready,
  output logic                 qry2_ready,
  output logic [31:0]          qry1_val,
  output logic [31:0]          qry2_val,
  input  logic                 flush
);
  localparam int N = 1 << ROB_POS_W;
  logic [N-1:0] busy, ready, has_rd;
  logic [4:0] rd [N];
  logic [31:0] val [N];
  logic [ROB_POS_W-1:0] head, tail;
  logic [ROB_POS_W:0] count;
  logic acc, ret, cdb_wr, hit1, hit2;
  always_comb begin
    acc = rdy && issue_valid && !rob_full && !flush;
    ret = rdy && !flush && count != '0 && ready[head];
    cdb_wr = rdy && cdb_valid && !flush && busy[cdb_rob_pos];
`ifdef ROB_CDB_BYPASS_EN
    hit1 = cdb_valid && cdb_rob_pos == qry1_pos;
    hit2 = cdb_valid && cdb_rob_pos == qry2_pos;
`else
    hit1 = 1'b0;
    hit2 = 1'b0;
`endif
  end
  // Outputs are forced quiet while rst is held, before the first edge clears state.
  assign rob_full = !rst && count[ROB_POS_W];
  assign issue_rob_pos = rst ? '0 : tail;
  assign rf_issue = !rst && acc && issue_has_rd && issue_rd != 5'd0;
  assign rf_issue_rd = issue_rd;
  assign rf_issue_rob_pos = tail;
  assign commit = !rst && ret && has_rd[head] && rd[head] != 5'd0;
  assign commit_rd = rd[head];
  assign commit_val = val[head];
  assign qry1_ready = !rst && (hit1 || ready[qry1_pos]);
  assign qry2_ready = !rst && (hit2 || ready[qry2_pos]);
  assign qry1_val = rst ? '0 : hit1 ? cdb_val : val[qry1_pos];
  assign qry2_val = rst ? '0 : hit2 ? cdb_val : val[qry2_pos];
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      busy <= '0;
      ready <= '0;
      has_rd <= '0;
      for (int i = 0; i < N; i++) begin
        rd[i] <= '0;
        val[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        busy <= '0;
        ready <= '0;
      end else begin
        if (cdb_wr) begin
          ready[cdb_rob_pos] <= 1'b1;
          val[cdb_rob_pos] <= cdb_val;
        end
        if (ret) begin
          busy[head] <= 1'b0;
          head <= head + 1'b1;
        end
        if (acc) begin
          busy[tail] <= 1'b1;
          ready[tail] <= 1'b0;
          has_rd[tail] <= issue_has_rd;
          rd[tail] <= issue_rd;
          tail <= tail + 1'b1;
        end
        count <= count + (ROB_POS_W+1)'(acc) - (ROB_POS_W+1)'(ret);
      end
    end
  end
endmodule

// File: doc/rob_core.md
ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 The parameter SHALL be ROB_POS_W, default 4, the entry index width; it is fixed at 4 so the 5-bit rename tag {1'b1,pos} stays consistent.
REQ-002 The port clk SHALL be an input, 1 bit wide, and serve as the clock.
REQ-003 The port rst SHALL be an input, 1 bit wide, and serve as the reset: synchronous, active-high.
REQ-004 The port rdy SHALL be an input, 1 bit wide; when low, the block freezes.
REQ-005 The inputs issue_valid (1), issue_has_rd (1) and issue_rd (5) SHALL carry a new instruction, whether it writes a register, and its destination register.
REQ-006 The outputs issue_rob_pos (4) and rob_full (1) SHALL carry the allocated slot (the tail) and the "cannot accept" flag.
REQ-007 The outputs rf_issue (1), rf_issue_rd (5) and rf_issue_rob_pos (4) SHALL form the rename request to the register file.
REQ-008 The inputs cdb_valid (1), cdb_rob_pos (4) and cdb_val (32) SHALL form the result broadcast.
REQ-009 The outputs commit (1), commit_rd (5) and commit_val (32) SHALL form the in-order retirement write to the register file.
REQ-010 The inputs qry1_pos and qry2_pos (4 bits each) SHALL select the operand lookup slots.
REQ-011 The outputs qry1_ready, qry2_ready (1 bit each) and qry1_val, qry2_val (32 bits each) SHALL return each selected slot's ready flag and value.
REQ-012 The input flush (1) SHALL discard all entries, for misprediction recovery.

Function
REQ-013 The block SHALL be a 16-entry circular buffer; each entry holds busy, ready, has_rd, rd[4:0] and val[31:0].
REQ-014 The block SHALL keep state in head (4 bits), tail (4 bits) and count (5 bits, 0..16); head and tail wrap 15->0.
REQ-015 rob_full SHALL equal (count==16), computed from registered count only; a same-cycle commit does not unblock issue.
REQ-016 issue_rob_pos SHALL equal tail, combinationally.
REQ-017 An issue SHALL be accepted when rdy && issue_valid && !rob_full && !flush.
REQ-018 On an accepted issue, at the clock edge, entry[tail] SHALL be set to busy=1, ready=0, has_rd and rd as presented; tail SHALL advance by 1.
REQ-019 rf_issue SHALL equal (accepted issue && issue_has_rd && issue_rd!=0); rf_issue_rd and rf_issue_rob_pos SHALL equal issue_rd and tail.
REQ-020 When rdy && cdb_valid && !flush, entry[cdb_rob_pos] SHALL take ready=1 and val=cdb_val at the edge; a CDB write to a non-busy entry SHALL be ignored.
REQ-021 Retire SHALL be decided combinationally as rdy && !flush && count!=0 && ready[head]; on retire, entry[head].busy SHALL be cleared and head SHALL advance at the edge.
REQ-022 The retire rate SHALL be at most 1 per cycle.
REQ-023 commit SHALL equal (retire && has_rd[head] && rd[head]!=0); commit_rd and commit_val SHALL equal rd[head] and val[head]; register x0 SHALL never be committed.
REQ-024 A CDB write to the head entry SHALL make it retire-eligible no earlier than the following cycle (one-cycle minimum latency).
REQ-025 On simultaneous accepted issue and retire, count SHALL be unchanged; otherwise count SHALL change by +1 or -1 accordingly.
REQ-026 The issue slot and the retiring slot SHALL never collide, because issue requires !full and retire requires count!=0.
REQ-027 qryN_ready SHALL equal ready[qryN_pos] and qryN_val SHALL equal val[qryN_pos], combinationally.
REQ-028 flush SHALL take precedence over issue, CDB and retire: at the edge, head=tail=count=0 and all busy and ready bits are cleared; commit and rf_issue SHALL be 0 in that cycle.
REQ-029 When rdy=0, state SHALL hold and commit and rf_issue SHALL be 0.

Reset
REQ-030 On rst, at the edge: head=tail=count=0, all busy, ready and val bits cleared; rst SHALL override rdy and flush.
REQ-031 During and after reset: rob_full=0, commit=0, rf_issue=0, issue_rob_pos=0, qry outputs=0.
REQ-032 An rst asserted mid-operation SHALL discard all in-flight entries with no commit emitted.

Configuration
REQ-033 The macro ROB_CDB_BYPASS_EN SHALL control CDB forwarding on operand lookups.
REQ-034 When ROB_CDB_BYPASS_EN is defined, qryN_ready SHALL be 1 and qryN_val SHALL be cdb_val whenever cdb_valid && cdb_rob_pos==qryN_pos in the same cycle.
REQ-035 When ROB_CDB_BYPASS_EN is undefined, the query outputs SHALL reflect registered entry state only, so a broadcast becomes visible one cycle later.

Verification
REQ-036 Scenario: issue rd=5 at pos0; CDB pos0 val=0x1234 -> in the next cycle, commit=1, commit_rd=5, commit_val=0x1234; count returns to 0.
REQ-037 Scenario: 16 issues with no CDB -> rob_full=1; a 17th issue_valid is not accepted (tail stays 0, rf_issue=0).
REQ-038 Scenario: fill to 16, CDB pos0, retire, and issue in the same cycle -> the issue is rejected that cycle and accepted the next cycle at pos0 (wrap); count=16.
REQ-039 Scenario: CDB pos2 then pos1 then pos0, out of order -> commits occur in order 0,1,2 on consecutive cycles.
REQ-040 Scenario: issue rd=0 and rd with has_rd=0 -> entries retire with commit=0 and rf_issue=0.
REQ-041 Scenario: 3 entries busy, flush with cdb_valid high -> count=0, no commit; the next issue is allocated at pos0.
